sprite_rom_arbiter: RTL

- Shares one single-port monster sprite ROM (45x45 pixels, 24-bit RGB, two animation frames) among NUM_REQ pixel requesters.
- Requesters are per-monster draw units.
- Block does round-robin arbitration, computes the linear pixel address, and generates the animation frame select from its own counter. This replaces the free-running timestamp modulo.
- Returns tagged pixel data with fixed latency. Sits between the monster draw units and the sprite ROM.

---
 rtl/sprite_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/sprite_rom_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite constants and types for the monster sprite ROM path.
package sprite_pkg;

  localparam int SPR_W      = 45;
  localparam int SPR_PIXELS = SPR_W * SPR_W;

  typedef logic [23:0] rgb_t;
  typedef logic [5:0]  spr_coord_t;

  localparam rgb_t TRANSPARENT_RGB = 24'hFFFFFF;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered last-winner pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] win_idx,
  output logic                       win_any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] last;
  int unsigned      idx;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    gnt     = '0;
    win_idx = last;
    win_any = 1'b0;
    idx     = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(last) + off) % NUM_REQ;
      if (!win_any && req[idx]) begin
        win_any = 1'b1;
        win_idx = IDX_W'(idx);
      end
    end
    if (!Reset_n) win_any = 1'b0;
    if (win_any) gnt[win_idx] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n)     last <= IDX_W'(NUM_REQ - 1);
    else if (win_any) last <= win_idx;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM among NUM_REQ draw units with fixed 2-cycle latency.
// Optional SPRITE_ANIM_FREEZE_EN adds anim_freeze to hold the animation counter.
module sprite_rom_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int SPR_W        = sprite_pkg::SPR_W,
  parameter int FRAME_PERIOD = 25000000,
  parameter int ADDR_W       = 19
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
`ifdef SPRITE_ANIM_FREEZE_EN
  input  logic                   anim_freeze,
`endif
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*6-1:0]   req_x,
  input  logic [NUM_REQ*6-1:0]   req_y,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic                   rom_frame,
  input  logic [23:0]            rom_data,
  output logic                   rd_valid,
  output logic [2:0]             rd_id,
  output logic [23:0]            rd_data
);

  import sprite_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  spr_coord_t        sel_x;
  spr_coord_t        sel_y;
  logic [ADDR_W-1:0] addr_next;
  logic              oob_next;

  logic [CNT_W-1:0]  anim_cnt;
  logic              anim_frame;
  logic              cnt_en;

  logic              s1_valid;
  logic [IDX_W-1:0]  s1_id;
  logic              s1_oob;
  logic              rd_oob;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .req     (req),
    .gnt     (gnt),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  always_comb begin
    sel_x     = req_x[32'(win_idx)*6 +: 6];
    sel_y     = req_y[32'(win_idx)*6 +: 6];
    addr_next = ADDR_W'(sel_y) * ADDR_W'(SPR_W) + ADDR_W'(sel_x);
    oob_next  = (32'(sel_x) >= SPR_W) || (32'(sel_y) >= SPR_W);
  end

`ifdef SPRITE_ANIM_FREEZE_EN
  assign cnt_en = ~anim_freeze;
`else
  assign cnt_en = 1'b1;
`endif

  assign anim_frame = (anim_cnt >= CNT_W'(FRAME_PERIOD / 2));

  always_ff @(posedge Clk) begin
    if (!Reset_n)    anim_cnt <= '0;
    else if (cnt_en) anim_cnt <= (anim_cnt == CNT_W'(FRAME_PERIOD - 1)) ? '0 : anim_cnt + 1'b1;
  end

  // Frame is latched with the address so a pixel always carries the frame of its grant cycle.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rom_addr  <= '0;
      rom_frame <= 1'b0;
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_oob    <= 1'b0;
    end else begin
      s1_valid <= win_any;
      if (win_any) begin
        rom_addr  <= addr_next;
        rom_frame <= anim_frame;
        s1_id     <= win_idx;
        s1_oob    <= oob_next;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
      rd_oob   <= 1'b0;
    end else begin
      rd_valid <= s1_valid;
      rd_id    <= 3'(s1_id);
      rd_oob   <= s1_oob;
    end
  end

  // ROM data arrives in the same cycle rd_valid rises, so the key substitution is a plain mux.
  assign rd_data = rd_oob ? TRANSPARENT_RGB : rom_data;

endmodule
